// File: rtl/multicyc_mcu.sv
// Multicycle main control FSM for the MIPS core: sequences FETCH/DECODE/EXEC/MEM/WB
// and drives per-state datapath enables, with a req/ready memory handshake and optional timeout.
module multicyc_mcu #(
   parameter int unsigned MEM_TIMEOUT     = 0,
   parameter int unsigned TO_W            = 8,
   parameter bit          HALT_ON_ILLEGAL = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_we,
   output logic       iord,
   output logic       ir_we,
   output logic       pc_we,
   output logic [1:0] pc_src,
   output logic       alu_srca_sel,
   output logic [1:0] alu_srcb_sel,
   output logic [3:0] aluop,
   output logic       reg_we,
   output logic       wreg_dst_sel,
   output logic       wreg_data_sel,
   output logic       instr_done,
   output logic       illegal_op,
   output logic       halted,
   output logic       mem_timeout
);

   localparam logic [5:0] OP_RR    = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [3:0] ALUop_ADD  = 4'h0;
   localparam logic [3:0] ALUop_ADDU = 4'h1;
   localparam logic [3:0] ALUop_SUB  = 4'h2;
   localparam logic [3:0] ALUop_RR   = 4'hF;

   localparam logic [TO_W-1:0] WAIT_LIMIT = TO_W'(MEM_TIMEOUT - 1);

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
      S_RREXEC, S_IMMEXEC, S_ALUWB, S_BRANCH, S_JUMP, S_HALT
   } state_e;

   typedef enum logic [2:0] {K_RR, K_LW, K_SW, K_ADDI, K_ADDIU, K_CTRL} kind_e;

   state_e          state_q, state_d;
   kind_e           kind_q, kind_d;
   logic [TO_W-1:0] wait_q, wait_d;
   logic            timeout_q, timeout_d;
   logic            expired;

   // The access that would bring the counter to the limit times out only if ready is still low.
   assign expired     = (MEM_TIMEOUT != 0) && (wait_q == WAIT_LIMIT);
   assign mem_timeout = timeout_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_FETCH;
         kind_q    <= K_RR;
         wait_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         kind_q    <= kind_d;
         wait_q    <= wait_d;
         timeout_q <= timeout_d;
      end
   end

   always_comb begin
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      iord          = 1'b0;
      ir_we         = 1'b0;
      pc_we         = 1'b0;
      pc_src        = 2'b00;
      alu_srca_sel  = 1'b0;
      alu_srcb_sel  = 2'b00;
      aluop         = ALUop_ADD;
      reg_we        = 1'b0;
      wreg_dst_sel  = 1'b0;
      wreg_data_sel = 1'b0;
      instr_done    = 1'b0;
      illegal_op    = 1'b0;
      halted        = 1'b0;
      state_d       = state_q;
      kind_d        = kind_q;
      wait_d        = '0;
      timeout_d     = timeout_q;

      case (state_q)
         S_FETCH: begin
            mem_req      = 1'b1;
            alu_srcb_sel = 2'b01;
            if (mem_ready) begin
               ir_we   = 1'b1;
               pc_we   = 1'b1;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            alu_srcb_sel = 2'b11;
            case (opcode)
               OP_LW:    begin kind_d = K_LW;    state_d = S_MEMADR;  end
               OP_SW:    begin kind_d = K_SW;    state_d = S_MEMADR;  end
               OP_RR:    begin kind_d = K_RR;    state_d = S_RREXEC;  end
               OP_ADDI:  begin kind_d = K_ADDI;  state_d = S_IMMEXEC; end
               OP_ADDIU: begin kind_d = K_ADDIU; state_d = S_IMMEXEC; end
               OP_BEQ:   begin kind_d = K_CTRL;  state_d = S_BRANCH;  end
               OP_J:     begin kind_d = K_CTRL;  state_d = S_JUMP;    end
               default: begin
                  illegal_op = 1'b1;
                  state_d    = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            alu_srca_sel = 1'b1;
            alu_srcb_sel = 2'b10;
            state_d      = (kind_q == K_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            mem_req = 1'b1;
            iord    = 1'b1;
            if (mem_ready) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            reg_we        = 1'b1;
            wreg_data_sel = 1'b1;
            instr_done    = 1'b1;
            state_d       = S_FETCH;
         end
         S_MEMWR: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            iord    = 1'b1;
            if (mem_ready) begin
               instr_done = 1'b1;
               state_d    = S_FETCH;
            end
         end
         S_RREXEC: begin
            alu_srca_sel = 1'b1;
            aluop        = ALUop_RR;
            state_d      = S_ALUWB;
         end
         S_IMMEXEC: begin
            alu_srca_sel = 1'b1;
            alu_srcb_sel = 2'b10;
            aluop        = (kind_q == K_ADDIU) ? ALUop_ADDU : ALUop_ADD;
            state_d      = S_ALUWB;
         end
         S_ALUWB: begin
            reg_we       = 1'b1;
            wreg_dst_sel = (kind_q == K_RR);
            instr_done   = 1'b1;
            state_d      = S_FETCH;
         end
         S_BRANCH: begin
            alu_srca_sel = 1'b1;
            aluop        = ALUop_SUB;
            pc_src       = 2'b01;
            pc_we        = zero;
            instr_done   = 1'b1;
            state_d      = S_FETCH;
         end
         S_JUMP: begin
            pc_src     = 2'b10;
            pc_we      = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_HALT:  halted  = 1'b1;
         default: state_d = S_FETCH;
      endcase

      // Counter resets on any state change, so it only accumulates while a request stalls.
      if (mem_req && !mem_ready) begin
         if (expired) begin
            state_d   = S_HALT;
            timeout_d = 1'b1;
         end else if (wait_q != '1) begin
            wait_d = wait_q + TO_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_multicyc_mcu.sv
// Directed bench for multicyc_mcu: one default instance, one with MEM_TIMEOUT=4 and HALT_ON_ILLEGAL=1.
module tb_multicyc_mcu;

   localparam logic [5:0] OP_RR = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_ADDI = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09, OP_LW = 6'h23, OP_SW = 6'h2B, OP_BAD = 6'h3F;
   localparam logic [3:0] A_ADD = 4'h0, A_ADDU = 4'h1, A_SUB = 4'h2, A_RR = 4'hF;

   logic       clk = 1'b0;
   logic       rst, zero, mem_ready;
   logic [5:0] opcode;

   logic       mem_req, mem_we, iord, ir_we, pc_we, alu_srca_sel, reg_we;
   logic       wreg_dst_sel, wreg_data_sel, instr_done, illegal_op, halted, mem_timeout;
   logic [1:0] pc_src, alu_srcb_sel;
   logic [3:0] aluop;

   logic       mem_req_b, mem_we_b, iord_b, ir_we_b, pc_we_b, alu_srca_sel_b, reg_we_b;
   logic       wreg_dst_sel_b, wreg_data_sel_b, instr_done_b, illegal_op_b, halted_b, mem_timeout_b;
   logic [1:0] pc_src_b, alu_srcb_sel_b;
   logic [3:0] aluop_b;

   int n_checks = 0;
   int n_errors = 0;
   int n_regwe  = 0;
   logic watch_regwe = 1'b0;

   always #5 clk = ~clk;

   multicyc_mcu dut (
      .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_we(ir_we), .pc_we(pc_we),
      .pc_src(pc_src), .alu_srca_sel(alu_srca_sel), .alu_srcb_sel(alu_srcb_sel),
      .aluop(aluop), .reg_we(reg_we), .wreg_dst_sel(wreg_dst_sel),
      .wreg_data_sel(wreg_data_sel), .instr_done(instr_done), .illegal_op(illegal_op),
      .halted(halted), .mem_timeout(mem_timeout)
   );

   multicyc_mcu #(.MEM_TIMEOUT(4), .TO_W(8), .HALT_ON_ILLEGAL(1'b1)) dut_b (
      .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .mem_req(mem_req_b), .mem_we(mem_we_b), .iord(iord_b), .ir_we(ir_we_b), .pc_we(pc_we_b),
      .pc_src(pc_src_b), .alu_srca_sel(alu_srca_sel_b), .alu_srcb_sel(alu_srcb_sel_b),
      .aluop(aluop_b), .reg_we(reg_we_b), .wreg_dst_sel(wreg_dst_sel_b),
      .wreg_data_sel(wreg_data_sel_b), .instr_done(instr_done_b), .illegal_op(illegal_op_b),
      .halted(halted_b), .mem_timeout(mem_timeout_b)
   );

   always @(posedge clk) if (watch_regwe && reg_we) n_regwe++;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input logic rdy, input logic [5:0] op, input logic z);
      @(negedge clk);
      mem_ready = rdy;
      opcode    = op;
      zero      = z;
      #1;
   endtask

   task automatic reset_release(input logic rdy, input logic [5:0] op);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst       = 1'b0;
      mem_ready = rdy;
      opcode    = op;
      zero      = 1'b0;
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; mem_ready = 1'b0; opcode = OP_RR; zero = 1'b0;
      #1;
      check_eq("rst mem_req", mem_req, 1);
      check_eq("rst iord", iord, 0);
      check_eq("rst srcb", alu_srcb_sel, 2'b01);
      check_eq("rst aluop", aluop, A_ADD);
      check_eq("rst halted", halted, 0);
      check_eq("rst timeout", mem_timeout, 0);
      check_eq("rst b mem_req", mem_req_b, 1);

      // RR: FETCH, DECODE, RREXEC, ALUWB
      @(negedge clk);
      rst = 1'b0; mem_ready = 1'b1; opcode = OP_RR;
      #1;
      check_eq("rr fetch ir_we", ir_we, 1);
      check_eq("rr fetch pc_we", pc_we, 1);
      check_eq("rr fetch pc_src", pc_src, 2'b00);
      cyc(1, OP_RR, 0);
      check_eq("rr dec mem_req", mem_req, 0);
      check_eq("rr dec srcb", alu_srcb_sel, 2'b11);
      check_eq("rr dec srca", alu_srca_sel, 0);
      cyc(1, OP_RR, 0);
      check_eq("rr exec aluop", aluop, A_RR);
      check_eq("rr exec srca", alu_srca_sel, 1);
      check_eq("rr exec srcb", alu_srcb_sel, 2'b00);
      check_eq("rr exec reg_we", reg_we, 0);
      check_eq("rr exec done", instr_done, 0);
      cyc(1, OP_RR, 0);
      check_eq("rr wb reg_we", reg_we, 1);
      check_eq("rr wb dst", wreg_dst_sel, 1);
      check_eq("rr wb data", wreg_data_sel, 0);
      check_eq("rr wb done", instr_done, 1);

      // LW, 3 wait cycles in MEMRD; opcode changed after DECODE must not matter
      cyc(1, OP_LW, 0);
      check_eq("lw fetch mem_req", mem_req, 1);
      check_eq("lw fetch done", instr_done, 0);
      cyc(1, OP_LW, 0);
      check_eq("lw dec srcb", alu_srcb_sel, 2'b11);
      cyc(0, OP_SW, 0);
      check_eq("lw adr srca", alu_srca_sel, 1);
      check_eq("lw adr srcb", alu_srcb_sel, 2'b10);
      check_eq("lw adr mem_req", mem_req, 0);
      for (int i = 0; i < 3; i++) begin
         cyc(0, OP_SW, 0);
         check_eq("lw rd wait mem_req", mem_req, 1);
         check_eq("lw rd wait iord", iord, 1);
         check_eq("lw rd wait mem_we", mem_we, 0);
         check_eq("lw rd wait ir_we", ir_we, 0);
      end
      cyc(1, OP_SW, 0);
      check_eq("lw rd rdy mem_req", mem_req, 1);
      check_eq("lw rd rdy iord", iord, 1);
      check_eq("lw rd rdy reg_we", reg_we, 0);
      cyc(1, OP_SW, 0);
      check_eq("lw wb reg_we", reg_we, 1);
      check_eq("lw wb data", wreg_data_sel, 1);
      check_eq("lw wb dst", wreg_dst_sel, 0);
      check_eq("lw wb done", instr_done, 1);
      check_eq("lw b no timeout", mem_timeout_b, 0);
      check_eq("lw b reg_we", reg_we_b, 1);

      // BEQ taken, then not taken
      cyc(1, OP_BEQ, 1);
      check_eq("beq1 fetch mem_req", mem_req, 1);
      cyc(1, OP_BEQ, 1);
      cyc(1, OP_BEQ, 1);
      check_eq("beq1 pc_we", pc_we, 1);
      check_eq("beq1 pc_src", pc_src, 2'b01);
      check_eq("beq1 aluop", aluop, A_SUB);
      check_eq("beq1 srca", alu_srca_sel, 1);
      check_eq("beq1 done", instr_done, 1);
      cyc(1, OP_BEQ, 0);
      check_eq("beq2 fetch mem_req", mem_req, 1);
      cyc(1, OP_BEQ, 0);
      cyc(1, OP_BEQ, 0);
      check_eq("beq2 pc_we", pc_we, 0);
      check_eq("beq2 pc_src", pc_src, 2'b01);
      check_eq("beq2 done", instr_done, 1);

      // J
      cyc(1, OP_J, 0);
      cyc(1, OP_J, 0);
      cyc(1, OP_J, 0);
      check_eq("j pc_src", pc_src, 2'b10);
      check_eq("j pc_we", pc_we, 1);
      check_eq("j done", instr_done, 1);

      // ADDIU then ADDI
      cyc(1, OP_ADDIU, 0);
      cyc(1, OP_ADDIU, 0);
      cyc(1, OP_ADDIU, 0);
      check_eq("addiu aluop", aluop, A_ADDU);
      check_eq("addiu srcb", alu_srcb_sel, 2'b10);
      cyc(1, OP_ADDIU, 0);
      check_eq("addiu wb reg_we", reg_we, 1);
      check_eq("addiu wb dst", wreg_dst_sel, 0);
      check_eq("addiu wb done", instr_done, 1);
      cyc(1, OP_ADDI, 0);
      cyc(1, OP_ADDI, 0);
      cyc(1, OP_ADDI, 0);
      check_eq("addi aluop", aluop, A_ADD);
      cyc(1, OP_ADDI, 0);
      check_eq("addi wb dst", wreg_dst_sel, 0);

      // SW zero-wait
      cyc(1, OP_SW, 0);
      cyc(1, OP_SW, 0);
      cyc(1, OP_SW, 0);
      check_eq("sw adr srcb", alu_srcb_sel, 2'b10);
      cyc(1, OP_SW, 0);
      check_eq("sw wr mem_we", mem_we, 1);
      check_eq("sw wr iord", iord, 1);
      check_eq("sw wr done", instr_done, 1);
      check_eq("sw wr reg_we", reg_we, 0);

      // Illegal opcode: refetch on default instance, halt on the other
      cyc(1, OP_BAD, 0);
      cyc(1, OP_BAD, 0);
      check_eq("ill pulse", illegal_op, 1);
      check_eq("ill b pulse", illegal_op_b, 1);
      cyc(1, OP_RR, 0);
      check_eq("ill pulse end", illegal_op, 0);
      check_eq("ill refetch", mem_req, 1);
      check_eq("ill not halted", halted, 0);
      check_eq("ill b halted", halted_b, 1);
      check_eq("ill b mem_req", mem_req_b, 0);

      // SW with ready stuck low: instance b times out after 4 wait cycles
      reset_release(1, OP_SW);
      check_eq("to b halted after rst", halted_b, 0);
      cyc(1, OP_SW, 0);
      cyc(0, OP_SW, 0);
      for (int i = 0; i < 4; i++) begin
         cyc(0, OP_SW, 0);
         check_eq("to b wait mem_we", mem_we_b, 1);
         check_eq("to b wait halted", halted_b, 0);
      end
      cyc(0, OP_SW, 0);
      check_eq("to b timeout", mem_timeout_b, 1);
      check_eq("to b halted", halted_b, 1);
      check_eq("to b mem_we", mem_we_b, 0);
      check_eq("to b mem_req", mem_req_b, 0);
      check_eq("to a still waiting", mem_we, 1);
      check_eq("to a no timeout", mem_timeout, 0);
      cyc(1, OP_SW, 0);
      check_eq("to b sticky", mem_timeout_b, 1);
      check_eq("to b stays halted", halted_b, 1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_eq("to b rst clears", mem_timeout_b, 0);
      check_eq("to b rst halted", halted_b, 0);
      check_eq("to b rst mem_req", mem_req_b, 1);

      // Reset in the middle of a MEMRD wait
      reset_release(1, OP_LW);
      cyc(1, OP_LW, 0);
      cyc(0, OP_LW, 0);
      cyc(0, OP_LW, 0);
      check_eq("abort in memrd iord", iord, 1);
      watch_regwe = 1'b1;
      rst = 1'b1;
      #1;
      check_eq("abort mem_req", mem_req, 1);
      check_eq("abort iord", iord, 0);
      check_eq("abort reg_we", reg_we, 0);
      @(negedge clk);
      rst = 1'b0; mem_ready = 1'b1; opcode = OP_RR;
      #1;
      check_eq("abort refetch iord", iord, 0);
      check_eq("abort refetch ir_we", ir_we, 1);
      cyc(1, OP_RR, 0);
      check_eq("abort decode srcb", alu_srcb_sel, 2'b11);
      watch_regwe = 1'b0;
      check_eq("abort reg_we count", n_regwe, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
